// File: rtl/text_buf_sched_pkg.sv
// Shared text-buffer definitions: RAM geometry, request record and scheduler state encoding.
package text_buf_sched_pkg;

  localparam int TEXT_ADDR_W = 8;
  localparam int CHAR_CODE_W = 7;
  localparam int LEVEL_W     = 5;

  localparam logic [CHAR_CODE_W-1:0] BLANK_CODE_DEF = 7'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [TEXT_ADDR_W-1:0] xy;
    logic [CHAR_CODE_W-1:0] code;
  } wr_req_t;

  localparam int WR_REQ_W = $bits(wr_req_t);

  // A pending clear always wins over queued cell writes.
  function automatic sched_state_e next_state(input logic clr_busy, input logic fifo_nonempty);
    if (clr_busy) begin
      return ST_CLEAR;
    end else if (fifo_nonempty) begin
      return ST_DRAIN;
    end
    return ST_IDLE;
  endfunction

endpackage

// File: rtl/text_buf_sched_fifo.sv
// Single-clock FIFO with a registered occupancy count; full/empty come from the count.
module sync_fifo #(
  parameter  int WIDTH = 15,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers are exactly log2(DEPTH) bits, so natural overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata      = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/text_buf_sched.sv
// Text RAM write scheduler: queues cell writes and full-screen clears, issuing RAM
// writes only while vertical blanking is active.
module text_buf_sched
  import text_buf_sched_pkg::*;
#(
  parameter int                     FIFO_DEPTH = 8,
  parameter logic [CHAR_CODE_W-1:0] BLANK_CODE = BLANK_CODE_DEF
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic                   vblnk_in,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [TEXT_ADDR_W-1:0] wr_xy,
  input  logic [CHAR_CODE_W-1:0] wr_code,
  input  logic                   clr_req,
  output logic                   clr_busy,
  output logic                   ram_we,
  output logic [TEXT_ADDR_W-1:0] ram_addr,
  output logic [CHAR_CODE_W-1:0] ram_data,
  output logic [LEVEL_W-1:0]     fifo_level,
  output logic                   overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  sched_state_e           state_q, state_d;
  logic                   clr_busy_q, clr_busy_d;
  logic [TEXT_ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic                   overflow_q, overflow_d;
  logic                   ready_en_q;
  logic                   ram_we_q, ram_we_d;
  logic [TEXT_ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [CHAR_CODE_W-1:0] ram_data_q, ram_data_d;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic [WR_REQ_W-1:0]    fifo_rdata;
  logic [CNT_W-1:0]       fifo_count;
  logic [CNT_W-1:0]       fifo_count_next;
  logic                   fifo_full;
  logic                   fifo_empty;
  wr_req_t                fifo_head;

  // ready_en_q keeps the port closed for the first edge after reset release.
  assign wr_ready  = ready_en_q && !fifo_full && !clr_busy_q;
  assign fifo_push = wr_valid && wr_ready;
  assign fifo_head = wr_req_t'(fifo_rdata);

  sync_fifo #(
    .WIDTH (WR_REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (pclk),
    .rst        (rst),
    .push       (fifo_push),
    .wdata      ({wr_xy, wr_code}),
    .pop        (fifo_pop),
    .rdata      (fifo_rdata),
    .count      (fifo_count),
    .count_next (fifo_count_next),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_comb begin
    clr_busy_d = clr_busy_q;
    clr_addr_d = clr_addr_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    fifo_pop   = 1'b0;
    overflow_d = overflow_q | (wr_valid & ~wr_ready);

    unique case (state_q)
      ST_CLEAR: begin
        if (vblnk_in) begin
          ram_we_d   = 1'b1;
          ram_addr_d = clr_addr_q;
          ram_data_d = BLANK_CODE;
          clr_addr_d = clr_addr_q + 1'b1;
          // Writing the last cell ends the clear; the wrapped counter is not reused.
          if (clr_addr_q == '1) begin
            clr_busy_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        if (vblnk_in && !fifo_empty) begin
          fifo_pop   = 1'b1;
          ram_we_d   = 1'b1;
          ram_addr_d = fifo_head.xy;
          ram_data_d = fifo_head.code;
        end
      end
      default: begin
      end
    endcase

    if (clr_req && !clr_busy_q) begin
      clr_busy_d = 1'b1;
      clr_addr_d = '0;
    end

    state_d = next_state(clr_busy_d, fifo_count_next != '0);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      clr_busy_q <= 1'b0;
      clr_addr_q <= '0;
      overflow_q <= 1'b0;
      ready_en_q <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_busy_q <= clr_busy_d;
      clr_addr_q <= clr_addr_d;
      overflow_q <= overflow_d;
      ready_en_q <= 1'b1;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
    end
  end

  assign clr_busy   = clr_busy_q;
  assign overflow   = overflow_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign fifo_level = LEVEL_W'(fifo_count);

endmodule

// File: tb/tb_text_buf_sched.sv
// Directed self-checking bench for text_buf_sched; every RAM write is logged and
// compared with hand-computed sequences.
module tb_text_buf_sched;

  logic       pclk;
  logic       rst;
  logic       vblnk_in;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_xy;
  logic [6:0] wr_code;
  logic       clr_req;
  logic       clr_busy;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [6:0] ram_data;
  logic [4:0] fifo_level;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic vb_edge = 1'b0;

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [6:0] d;
    logic       vb;
  } wlog_t;
  wlog_t wlog[$];

  text_buf_sched #(
    .FIFO_DEPTH (8),
    .BLANK_CODE (7'h20)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .vblnk_in   (vblnk_in),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_xy      (wr_xy),
    .wr_code    (wr_code),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    cyc     <= cyc + 1;
    vb_edge <= vblnk_in;
  end

  // vb records the blanking value the write was decided on.
  always @(negedge pclk) begin
    if (ram_we === 1'b1) begin
      wlog.push_back('{cyc, ram_addr, ram_data, vb_edge});
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int k0;
    int n;
    int bad;
    int span;
    bit found;

    rst      = 1'b1;
    vblnk_in = 1'b0;
    wr_valid = 1'b0;
    wr_xy    = 8'h00;
    wr_code  = 7'h00;
    clr_req  = 1'b0;

    // Reset state
    step(); step(); step();
    chk("rst_wr_ready",   32'(wr_ready), 32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_clr_busy",   32'(clr_busy), 32'd0);
    chk("rst_overflow",   32'(overflow), 32'd0);
    chk("rst_ram_we",     32'(ram_we), 32'd0);
    chk("rst_ram_addr",   32'(ram_addr), 32'd0);
    chk("rst_ram_data",   32'(ram_data), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_before_first_edge", 32'(wr_ready), 32'd0);
    step();
    chk("ready_after_first_edge", 32'(wr_ready), 32'd1);

    // Single write, two-cycle latency
    vblnk_in = 1'b1;
    step();
    wlog.delete();
    wr_valid = 1'b1; wr_xy = 8'h12; wr_code = 7'h41;
    step();
    wr_valid = 1'b0;
    chk("lat_c1_level", 32'(fifo_level), 32'd1);
    chk("lat_c1_we", 32'(ram_we), 32'd0);
    step();
    chk("lat_c2_we", 32'(ram_we), 32'd1);
    chk("lat_c2_addr", 32'(ram_addr), 32'h12);
    chk("lat_c2_data", 32'(ram_data), 32'h41);
    step();
    chk("lat_c3_we", 32'(ram_we), 32'd0);
    chk("lat_c3_addr_hold", 32'(ram_addr), 32'h12);
    chk("lat_write_count", 32'(wlog.size()), 32'd1);

    // Fill FIFO with blanking low, overflow, then drain in order
    vblnk_in = 1'b0;
    wlog.delete();
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_xy = 8'h30 + 8'(i); wr_code = 7'h50 + 7'(i);
      step();
    end
    chk("full_level", 32'(fifo_level), 32'd8);
    chk("full_ready", 32'(wr_ready), 32'd0);
    wr_xy = 8'h99; wr_code = 7'h7f;
    step();
    wr_valid = 1'b0;
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(fifo_level), 32'd8);
    for (int i = 0; i < 5; i++) step();
    chk("no_write_without_vblnk", 32'(wlog.size()), 32'd0);
    vblnk_in = 1'b1;
    n = 0;
    while (fifo_level != 5'd0 && n < 30) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(fifo_level), 32'd0);
    step(); step();
    chk("drain_count", 32'(wlog.size()), 32'd8);
    if (wlog.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("drain_entry%0d", i), {17'd0, wlog[i].a, wlog[i].d},
            {17'd0, 8'h30 + 8'(i), 7'h50 + 7'(i)});
      end
    end

    // Full clear with blanking continuously high
    wlog.delete();
    clr_req = 1'b1;
    k0 = cyc;
    step();
    clr_req = 1'b0;
    chk("clr_ready_low", 32'(wr_ready), 32'd0);
    n = 0;
    while (clr_busy === 1'b1 && n < 400) begin
      n++;
      step();
    end
    chk("clr_busy_cycles", 32'(n), 32'd256);
    step(); step();
    chk("clr_write_count", 32'(wlog.size()), 32'd256);
    bad = 0;
    for (int i = 0; i < wlog.size(); i++) begin
      if (wlog[i].a != i[7:0] || wlog[i].d != 7'h20 || wlog[i].cyc != wlog[0].cyc + i) bad++;
    end
    chk("clr_seq_bad", 32'(bad), 32'd0);
    if (wlog.size() > 0) chk("clr_first_cycle", 32'(wlog[0].cyc), 32'(k0 + 2));

    // Clear with blanking toggling 100 high / 50 low
    wlog.delete();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int s = 0; s < 800; s++) begin
      vblnk_in = ((s % 150) < 100);
      step();
      if (clr_busy !== 1'b1) break;
    end
    chk("tog_done", 32'(clr_busy), 32'd0);
    vblnk_in = 1'b1;
    step(); step();
    chk("tog_write_count", 32'(wlog.size()), 32'd256);
    bad = 0;
    for (int i = 0; i < wlog.size(); i++) begin
      if (wlog[i].a != i[7:0] || wlog[i].d != 7'h20 || wlog[i].vb != 1'b1) bad++;
    end
    chk("tog_seq_bad", 32'(bad), 32'd0);
    if (wlog.size() > 0) begin
      chk("tog_last_addr", 32'(wlog[wlog.size()-1].a), 32'hff);
      span = wlog[wlog.size()-1].cyc - wlog[0].cyc;
      chk("tog_paused", 32'(span > 255), 32'd1);
    end

    // Queued write survives a clear and lands afterwards
    vblnk_in = 1'b0;
    wlog.delete();
    wr_valid = 1'b1; wr_xy = 8'h05; wr_code = 7'h33;
    step();
    wr_valid = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    chk("q_clr_busy", 32'(clr_busy), 32'd1);
    chk("q_level_kept", 32'(fifo_level), 32'd1);
    vblnk_in = 1'b1;
    n = 0;
    while ((clr_busy !== 1'b0 || fifo_level != 5'd0) && n < 400) begin
      step();
      n++;
    end
    chk("q_idle", 32'(fifo_level), 32'd0);
    step(); step(); step();
    chk("q_write_count", 32'(wlog.size()), 32'd257);
    if (wlog.size() == 257) begin
      chk("q_blank5", {24'd0, wlog[5].a, 1'b0, wlog[5].d}, {24'd0, 8'h05, 8'h20});
      chk("q_last_clear", 32'(wlog[255].a), 32'hff);
      chk("q_final_write", {24'd0, wlog[256].a, 1'b0, wlog[256].d}, {24'd0, 8'h05, 8'h33});
    end
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of a clear
    vblnk_in = 1'b0;
    wr_valid = 1'b1; wr_xy = 8'h40; wr_code = 7'h11;
    step();
    wr_valid = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    vblnk_in = 1'b1;
    found = 1'b0;
    for (int s = 0; s < 300; s++) begin
      step();
      if (ram_we === 1'b1 && ram_addr === 8'h80) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_clr_reached_0x80", 32'(found), 32'd1);
    chk("mid_clr_level", 32'(fifo_level), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_ram_we", 32'(ram_we), 32'd0);
    chk("arst_clr_busy", 32'(clr_busy), 32'd0);
    chk("arst_ram_addr", 32'(ram_addr), 32'd0);
    step(); step();
    rst = 1'b0;
    wlog.delete();
    for (int s = 0; s < 300; s++) step();
    chk("post_rst_writes", 32'(wlog.size()), 32'd0);
    chk("post_rst_clr_busy", 32'(clr_busy), 32'd0);
    chk("post_rst_level", 32'(fifo_level), 32'd0);
    chk("post_rst_overflow", 32'(overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_buf_sched.md
TEXT_BUF_SCHED -- requirements
Module: text_buf_sched

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of queued write requests (power of two, 2..16).
REQ-002 Parameter BLANK_CODE, default 7'h20, character code written by a screen clear.
REQ-003 pclk  in  1  pixel clock; every register is clocked on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 vblnk_in  in  1  vertical blanking from the timing chain; text RAM writes are permitted while it is high.
REQ-006 wr_valid  in  1  write request present.
REQ-007 wr_ready  out  1  request accepted this cycle when wr_valid is also high.
REQ-008 wr_xy  in  8  text cell address {row[3:0], col[3:0]}.
REQ-009 wr_code  in  7  character code for that cell.
REQ-010 clr_req  in  1  single-cycle pulse requesting a full-screen clear.
REQ-011 clr_busy  out  1  clear pending or in progress.
REQ-012 ram_we  out  1  text RAM write strobe, registered.
REQ-013 ram_addr  out  8  text RAM write address, registered.
REQ-014 ram_data  out  7  text RAM write data, registered.
REQ-015 fifo_level  out  5  number of queued requests, 0..FIFO_DEPTH.
REQ-016 overflow  out  1  sticky flag; set when wr_valid is high while wr_ready is low.

Function
REQ-017 Handshake: a request is accepted on a rising edge where wr_valid && wr_ready.
- Each accepted {wr_xy, wr_code} is pushed into the FIFO in arrival order.
REQ-018 wr_ready = !full && !clr_busy.
- wr_ready is combinational from registered state only.
- It never depends on wr_valid.
REQ-019 FSM states:
- IDLE: no RAM writes.
- DRAIN: pop one FIFO entry per cycle.
- CLEAR: write one cell per cycle.
REQ-020 Transitions are evaluated each cycle in this priority order:
- clr_busy → CLEAR
- else FIFO non-empty → DRAIN
- else IDLE.
REQ-021 Writes are gated by vblnk_in:
- DRAIN and CLEAR issue a write only in a cycle where vblnk_in is sampled high.
- Otherwise the FSM holds its position with no write.
REQ-022 Write latency: a write decided in cycle N appears on ram_we/ram_addr/ram_data in cycle N+1 for exactly one cycle.
- ram_addr and ram_data hold their last value when ram_we is low.
REQ-023 Drain latency: a request accepted in cycle N, with the FIFO empty, no clear pending and vblnk_in high, reaches ram_we in cycle N+2.
REQ-024 Clear sequence:
- A clr_req pulse sets clr_busy on the next edge.
- CLEAR writes BLANK_CODE to addresses 0x00..0xFF ascending, 256 writes in total.
- clr_busy drops on the edge that issues the write to 0xFF.
REQ-025 A clear pauses whenever vblnk_in is low and resumes at the next unwritten address.
REQ-026 clr_req while clr_busy is high is ignored; the clear does not restart.
REQ-027 Clear has priority over queued requests.
- FIFO contents are retained during a clear.
- They drain after the clear completes, so later writes overwrite blanks.
REQ-028 A push and a pop in the same cycle leave fifo_level unchanged.
- A push into an empty FIFO is not popped in the same cycle.
REQ-029 FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
- Full and empty are derived from a separate count register, never from pointer equality alone.
REQ-030 The clear address counter is 8 bits.
- Its wrap from 0xFF terminates the clear; it does not start a second pass.
REQ-031 overflow is cleared only by rst.

Reset
REQ-032 While rst is high, all of the following hold:
- FSM is in IDLE; FIFO is empty; fifo_level = 0.
- clr_busy = 0; overflow = 0.
- ram_we = 0; ram_addr = 0; ram_data = 0.
REQ-033 rst asserted mid-drain or mid-clear abandons the operation.
- No further writes occur.
- A partially cleared screen is not completed.
REQ-034 wr_ready is 0 while rst is high and for the first edge after release.

Structure
REQ-035 The shared VGA package holds TEXT_ADDR_W = 8, CHAR_CODE_W = 7, BLANK_CODE default and the state encodings.
REQ-036 The FIFO is one sub-module, sync_fifo: parameterised width and depth, single clock, registered count.
REQ-037 No other sub-modules are used.
REQ-038 The one-cycle write lag past the end of vblnk_in is acceptable, because display reads of line 0 occur several pipeline stages later.

Verification
REQ-039 With vblnk_in=1, push {0x12, 0x41} in cycle 0 → ram_we=1, ram_addr=0x12, ram_data=0x41 in cycle 2 only.
REQ-040 With vblnk_in=0, push 8 requests then a 9th → wr_ready=0, fifo_level=8, overflow=1; no ram_we until vblnk_in rises; then 8 writes in push order.
REQ-041 With vblnk_in=1 continuously, pulse clr_req → 256 consecutive writes of 0x20 to 0x00..0xFF; clr_busy high for exactly 256 cycles.
REQ-042 clr_req with vblnk_in toggling 100 cycles high, 50 low → writes only in the cycle after a high sample; addresses contiguous across pauses; final address 0xFF.
REQ-043 Queue {0x05, 0x33}, then clr_req before vblnk_in → 256 clear writes, then the 0x05 write; cell 0x05 ends at 0x33.
REQ-044 Assert rst at clear address 0x80 → ram_we=0 immediately; after release, clr_busy=0, fifo_level=0, no writes.
